// File: rtl/audio_sample_pacer_if.sv
// Handshake bundle around audio_sample_pacer: player-side sample stream in, codec-side
// Avalon-ST samples out. The pacer connects through "master"; the player/codec side uses "slave".
interface audio_sample_pacer_if;
    logic [15:0] sample_data_l;
    logic        sample_valid_l;
    logic [15:0] sample_data_r;
    logic        sample_valid_r;
    logic        left_chan_ready;
    logic        right_chan_ready;
    logic [15:0] codec_l_data;
    logic        codec_l_valid;
    logic        codec_l_ready;
    logic [15:0] codec_r_data;
    logic        codec_r_valid;
    logic        codec_r_ready;

    modport master (
        input  sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
        input  codec_l_ready, codec_r_ready,
        output left_chan_ready, right_chan_ready,
        output codec_l_data, codec_l_valid, codec_r_data, codec_r_valid
    );

    modport slave (
        output sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
        output codec_l_ready, codec_r_ready,
        input  left_chan_ready, right_chan_ready,
        input  codec_l_data, codec_l_valid, codec_r_data, codec_r_valid
    );
endinterface

// File: rtl/audio_sample_pacer.sv
// Paces the ROM sample player at the codec rate and turns its offset-binary streams into
// signed, volume-scaled codec samples. Define AUDIO_PACER_MIX_EN for a saturated mono mix.
module audio_sample_pacer #(
    parameter int CLK_DIV = 6250,
    parameter int SETTLE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    audio_sample_pacer_if.master bus,
    input  logic [2:0]           vol_bgm,
    input  logic [2:0]           vol_sfx,
    input  logic                 mute,
    output logic [15:0]          underrun_count,
    output logic [15:0]          overrun_count
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, REQ, SETTLE_W, DRAIN} state_t;

    state_t         r_state, w_state_nxt;
    logic [TW-1:0]  r_tick_cnt;
    logic [SW-1:0]  r_settle_cnt;
    logic           r_pending;
    logic [15:0]    r_l_data, r_r_data;
    logic           r_l_valid, r_r_valid;
    logic [15:0]    r_underrun, r_overrun;

    logic w_tick, w_both_valid, w_ready;
    logic w_settle_load, w_capture, w_silence, w_underrun, w_pending_set, w_pending_clr;
    logic w_push, w_overrun;

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_both_valid = bus.sample_valid_l && bus.sample_valid_r;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_ready       = 1'b0;
        w_settle_load = 1'b0;
        w_capture     = 1'b0;
        w_silence     = 1'b0;
        w_underrun    = 1'b0;
        w_pending_set = 1'b0;
        w_pending_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick || r_pending) begin
                    w_state_nxt   = REQ;
                    w_pending_clr = 1'b1;
                end
            end
            REQ: begin
                w_ready = 1'b1;
                if (w_both_valid) begin
                    w_settle_load = 1'b1;
                    w_state_nxt   = SETTLE_W;
                    // the new period starts before this sample lands: catch it up afterwards
                    w_pending_set = w_tick;
                    w_underrun    = w_tick;
                end else if (w_tick) begin
                    w_silence  = 1'b1;
                    w_underrun = 1'b1;
                end
            end
            SETTLE_W: begin
                w_ready       = 1'b1;
                w_pending_set = w_tick;
                w_underrun    = w_tick;
                if (r_settle_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_pending_set = w_tick;
                w_underrun    = w_tick;
                if (!bus.sample_valid_l && !bus.sample_valid_r) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_settle_cnt <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_settle_load)
                r_settle_cnt <= SETTLE_LOAD;
            else if (r_state == SETTLE_W && r_settle_cnt != '0)
                r_settle_cnt <= r_settle_cnt - SW'(1);
            if (w_pending_set)
                r_pending <= 1'b1;
            else if (w_pending_clr)
                r_pending <= 1'b0;
        end
    end

    // Offset binary -> two's complement, then attenuate with sign extension
    logic signed [15:0] w_s_l, w_s_r, w_a_l, w_a_r, w_out_l, w_out_r;
    assign w_s_l = {~bus.sample_data_l[15], bus.sample_data_l[14:0]};
    assign w_s_r = {~bus.sample_data_r[15], bus.sample_data_r[14:0]};
    assign w_a_l = w_s_l >>> vol_bgm;
    assign w_a_r = w_s_r >>> vol_sfx;

`ifdef AUDIO_PACER_MIX_EN
    logic signed [16:0] w_sum;
    logic signed [15:0] w_mix;
    assign w_sum = {w_a_l[15], w_a_l} + {w_a_r[15], w_a_r};
    always_comb begin
        w_mix = w_sum[15:0];
        if (w_sum[16] != w_sum[15]) w_mix = w_sum[16] ? 16'sh8000 : 16'sh7FFF;
    end
    assign w_out_l = mute ? 16'sh0000 : w_mix;
    assign w_out_r = mute ? 16'sh0000 : w_mix;
`else
    assign w_out_l = mute ? 16'sh0000 : w_a_l;
    assign w_out_r = mute ? 16'sh0000 : w_a_r;
`endif

    assign w_push    = w_capture || w_silence;
    assign w_overrun = w_push && ((r_l_valid && !bus.codec_l_ready) ||
                                  (r_r_valid && !bus.codec_r_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_data   <= '0;
            r_r_data   <= '0;
            r_l_valid  <= 1'b0;
            r_r_valid  <= 1'b0;
            r_underrun <= '0;
            r_overrun  <= '0;
        end else begin
            if (w_push) begin
                r_l_data  <= w_capture ? w_out_l : '0;
                r_r_data  <= w_capture ? w_out_r : '0;
                r_l_valid <= 1'b1;
                r_r_valid <= 1'b1;
            end else begin
                if (r_l_valid && bus.codec_l_ready) r_l_valid <= 1'b0;
                if (r_r_valid && bus.codec_r_ready) r_r_valid <= 1'b0;
            end
            if (w_underrun && r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'd1;
            if (w_overrun && r_overrun != 16'hFFFF)   r_overrun  <= r_overrun + 16'd1;
        end
    end

    assign bus.left_chan_ready  = w_ready;
    assign bus.right_chan_ready = w_ready;
    assign bus.codec_l_data     = r_l_data;
    assign bus.codec_r_data     = r_r_data;
    assign bus.codec_l_valid    = r_l_valid;
    assign bus.codec_r_valid    = r_r_valid;
    assign underrun_count       = r_underrun;
    assign overrun_count        = r_overrun;
endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: conversion table plus pacing, underrun, overrun
// and asynchronous-reset sequences against a simple ROM player model.
module tb_audio_sample_pacer;
    localparam int CLK_DIV = 20;
    localparam int SETTLE  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  vol_bgm = '0, vol_sfx = '0;
    logic        mute = 1'b0;
    logic [15:0] underrun_count, overrun_count;
    bit          player_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    audio_sample_pacer_if bus_if();

    audio_sample_pacer #(.CLK_DIV(CLK_DIV), .SETTLE(SETTLE)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if),
        .vol_bgm        (vol_bgm),
        .vol_sfx        (vol_sfx),
        .mute           (mute),
        .underrun_count (underrun_count),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    // Player: on its first ready seen while idle, raises valid one cycle later, drops it once ready falls
    bit p_busy, p_adv;
    always @(negedge clk) begin
        if (reset) begin
            p_busy = 1'b0;
            p_adv  = 1'b0;
            bus_if.sample_valid_l = 1'b0;
            bus_if.sample_valid_r = 1'b0;
        end else if (p_adv) begin
            p_adv = 1'b0;
            bus_if.sample_valid_l = 1'b1;
            bus_if.sample_valid_r = 1'b1;
        end else if (p_busy && !bus_if.left_chan_ready) begin
            p_busy = 1'b0;
            bus_if.sample_valid_l = 1'b0;
            bus_if.sample_valid_r = 1'b0;
        end else if (!p_busy && bus_if.left_chan_ready && player_en) begin
            p_busy = 1'b1;
            p_adv  = 1'b1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Negedges counted until ready goes low (if high) and then high again
    task automatic wait_ready_rise(output int n, output bit ok);
        bit seen_low = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            @(negedge clk);
            n++;
            if (!bus_if.left_chan_ready) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_push(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(negedge clk);
            if (bus_if.codec_r_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] dl, dr;
        logic [2:0]  vb, vs;
        logic        m;
        logic [15:0] el, er;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  n;
        bit  ok;
        int  pushes, bad_silence;
        bit  rdy_seen, rdy_dropped;

`ifdef AUDIO_PACER_MIX_EN
        vecs[0] = '{16'h8000, 16'h8000, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{16'hFF00, 16'h0000, 3'd1, 3'd0, 1'b0, 16'hBF80, 16'hBF80};
        vecs[2] = '{16'hFF00, 16'hFF00, 3'd0, 3'd0, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h8000, 16'h8000};
        vecs[4] = '{16'h0000, 16'hFF00, 3'd7, 3'd3, 1'b0, 16'h0EE0, 16'h0EE0};
        vecs[5] = '{16'hFF00, 16'h0000, 3'd0, 3'd0, 1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{16'h1234, 16'hABCD, 3'd2, 3'd5, 1'b0, 16'hE5EB, 16'hE5EB};
`else
        vecs[0] = '{16'h8000, 16'h8000, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{16'hFF00, 16'h0000, 3'd1, 3'd0, 1'b0, 16'h3F80, 16'h8000};
        vecs[2] = '{16'hFF00, 16'hFF00, 3'd0, 3'd0, 1'b0, 16'h7F00, 16'h7F00};
        vecs[3] = '{16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h8000, 16'h8000};
        vecs[4] = '{16'h0000, 16'hFF00, 3'd7, 3'd3, 1'b0, 16'hFF00, 16'h0FE0};
        vecs[5] = '{16'hFF00, 16'h0000, 3'd0, 3'd0, 1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{16'h1234, 16'hABCD, 3'd2, 3'd5, 1'b0, 16'hE48D, 16'h015E};
`endif

        bus_if.sample_data_l = 16'h8000;
        bus_if.sample_data_r = 16'h8000;
        bus_if.codec_l_ready = 1'b1;
        bus_if.codec_r_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {15'd0, bus_if.left_chan_ready}, 16'd0);
        check("rst_l_valid", {15'd0, bus_if.codec_l_valid}, 16'd0);
        check("rst_r_valid", {15'd0, bus_if.codec_r_valid}, 16'd0);
        check("rst_l_data", bus_if.codec_l_data, 16'h0000);
        check("rst_r_data", bus_if.codec_r_data, 16'h0000);
        check("rst_underrun", underrun_count, 16'd0);
        check("rst_overrun", overrun_count, 16'd0);

        // Pacing: first request CLK_DIV cycles after release, then one per period
        reset = 1'b0;
        wait_ready_rise(n, ok);
        if (!ok) timeout("first_req");
        else check("first_req_cycles", 16'(n), 16'(CLK_DIV));
        check("ready_r_eq_l", {15'd0, bus_if.right_chan_ready}, {15'd0, bus_if.left_chan_ready});
        wait_ready_rise(n, ok);
        if (!ok) timeout("req_period");
        else check("req_period_cycles", 16'(n), 16'(CLK_DIV));

        // Conversion table
        for (int i = 0; i < 7; i++) begin
            bus_if.sample_data_l = vecs[i].dl;
            bus_if.sample_data_r = vecs[i].dr;
            vol_bgm = vecs[i].vb;
            vol_sfx = vecs[i].vs;
            mute    = vecs[i].m;
            wait_push(ok);
            if (!ok) timeout($sformatf("vec%0d_push", i));
            else begin
                check($sformatf("vec%0d_l", i), bus_if.codec_l_data, vecs[i].el);
                check($sformatf("vec%0d_r", i), bus_if.codec_r_data, vecs[i].er);
            end
        end
        mute = 1'b0;
        vol_bgm = '0;
        vol_sfx = '0;
        check("underrun_none", underrun_count, 16'd0);

        // Underrun: player silent for three periods
        player_en = 1'b0;
        bus_if.sample_data_l = 16'hFF00;
        bus_if.sample_data_r = 16'hFF00;
        do_reset();
        pushes = 0;
        bad_silence = 0;
        rdy_seen = 1'b0;
        rdy_dropped = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV + 4; i++) begin
            @(negedge clk);
            if (bus_if.left_chan_ready) rdy_seen = 1'b1;
            else if (rdy_seen) rdy_dropped = 1'b1;
            if (bus_if.codec_r_valid) begin
                pushes++;
                if (bus_if.codec_l_data != 16'h0000 || bus_if.codec_r_data != 16'h0000) bad_silence++;
            end
        end
        check("silence_pushes", 16'(pushes), 16'd3);
        check("silence_data_bad", 16'(bad_silence), 16'd0);
        check("underrun_3", underrun_count, 16'd3);
        check("ready_held", {15'd0, rdy_dropped}, 16'd0);
        check("ready_high", {15'd0, bus_if.left_chan_ready}, 16'd1);
        player_en = 1'b1;

        // Overrun: left codec stalled across two pushes
        bus_if.codec_l_ready = 1'b0;
        bus_if.sample_data_l = 16'hFF00;
        bus_if.sample_data_r = 16'h8000;
        do_reset();
        wait_push(ok);
        if (!ok) timeout("ovr_push1");
        check("ovr_push1_valid", {15'd0, bus_if.codec_l_valid}, 16'd1);
        check("ovr_push1_count", overrun_count, 16'd0);
        bus_if.sample_data_l = 16'h0000;
        wait_push(ok);
        if (!ok) timeout("ovr_push2");
        check("ovr_latest_data", bus_if.codec_l_data, 16'h8000);
        check("ovr_valid", {15'd0, bus_if.codec_l_valid}, 16'd1);
        check("ovr_count", overrun_count, 16'd1);

        // Codec ready rising in the push cycle: new sample kept, no overrun
        bus_if.sample_data_l = 16'hFF00;
        wait_ready_rise(n, ok);
        if (!ok) timeout("same_cycle_req");
        repeat (SETTLE + 1) @(negedge clk);
        bus_if.codec_l_ready = 1'b1;
        @(negedge clk);
        check("same_cycle_valid", {15'd0, bus_if.codec_l_valid}, 16'd1);
        check("same_cycle_data", bus_if.codec_l_data, 16'h7F00);
        check("same_cycle_overrun", overrun_count, 16'd1);
        @(negedge clk);
        check("same_cycle_drain", {15'd0, bus_if.codec_l_valid}, 16'd0);

        // Asynchronous reset while in SETTLE_W
        wait_ready_rise(n, ok);
        if (!ok) timeout("arst_req");
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ready", {15'd0, bus_if.left_chan_ready}, 16'd0);
        check("arst_l_valid", {15'd0, bus_if.codec_l_valid}, 16'd0);
        check("arst_r_valid", {15'd0, bus_if.codec_r_valid}, 16'd0);
        check("arst_l_data", bus_if.codec_l_data, 16'h0000);
        check("arst_overrun", overrun_count, 16'd0);
        check("arst_underrun", underrun_count, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ready_rise(n, ok);
        if (!ok) timeout("arst_first_req");
        else check("arst_first_req_cycles", 16'(n), 16'(CLK_DIV));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_sample_pacer.md
# audio_sample_pacer

Downstream stage of the ROM sample player: paces it at the codec sample rate and converts its two 8-bit-in-16 unsigned streams (left = BGM, right = SFX) into signed, volume-scaled samples. It drives the player's `left_chan_ready`/`right_chan_ready` and hands the results to the audio codec's Avalon-ST sink ports. It also counts underruns and overruns for the CPU.

## Interface
- `CLK_DIV`, 6250, clocks per sample period (50 MHz / 8 kHz); must be ≥ 16.
- `SETTLE`, 3, wait in clocks from seeing valid to capturing data; covers the player's address register plus ROM read latency.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_data_l`  in  16  BGM sample, unsigned, byte in [15:8].
- `sample_valid_l`  in  1  BGM valid.
- `sample_data_r`  in  16  SFX sample, same format.
- `sample_valid_r`  in  1  SFX valid.
- `left_chan_ready`, `right_chan_ready`  out  1 each  request to the player; always equal.
- `vol_bgm`, `vol_sfx`  in  3 each  attenuation, arithmetic right shift 0–7.
- `mute`  in  1  forces output data to 0; pacing continues.
- `codec_l_data`, `codec_r_data`  out  16 each  signed output samples.
- `codec_l_valid`, `codec_r_valid`  out  1 each.
- `codec_l_ready`, `codec_r_ready`  in  1 each.
- `underrun_count`  out  16  saturating count of underruns.
- `overrun_count`  out  16  saturating count of overruns.

## Operation
- Tick counter: runs 0..CLK_DIV-1 and wraps. `tick` is asserted in the cycle the counter equals CLK_DIV-1.
- FSM states: IDLE, REQ, SETTLE_W, DRAIN.
- IDLE: ready=0. On `tick`, or if `pending`=1, go to REQ and clear `pending`.
- REQ: ready=1.
  - When `sample_valid_l && sample_valid_r`, load the settle counter with SETTLE-1 and go to SETTLE_W.
  - On `tick` while still in REQ (player idle): push silence (0,0), underrun_count++, stay in REQ.
- SETTLE_W: ready=1. When the settle counter reaches 0:
  - capture both inputs;
  - push the processed pair;
  - go to DRAIN.
- DRAIN: ready=0. When both valids are 0, go to IDLE.
- `tick` arriving in SETTLE_W or DRAIN: set `pending`, underrun_count++.
- Conversion, per channel:
  - s = {~d[15], d[14:0]}, i.e. offset binary to two's complement;
  - a = s >>> vol, sign-extending;
  - out = mute ? 0 : a.
- Push to a codec channel:
  - load data and set valid;
  - if valid was already 1 and not accepted (ready=0) in this cycle: overwrite and overrun_count++. Overrun counting is per event, and both channels overrunning together count as 1.
  - A push and an acceptance in the same cycle: the new sample wins, valid stays 1, no overrun.
- valid clears on valid&&ready when there is no simultaneous push.
- Counters stick at 0xFFFF.

## Timing
- Reset values:
  - ready = 0;
  - all codec data = 0 and all codec valid = 0;
  - counters = 0, `pending` = 0;
  - tick counter = 0, FSM = IDLE.
- Reset asserted mid-operation returns everything above to these values immediately.
- Ready rises one cycle after `tick`.
- Capture happens SETTLE cycles after the first cycle both valids are seen high. codec_*_valid rises on the next edge.
- Exactly one player advance per sample period: ready is held until capture and then dropped. The player advances only on its first ready cycle while not busy.
- Volume and mute are sampled in the capture cycle.

## Configuration
- `AUDIO_PACER_MIX_EN` defined: both outputs carry the mono mix.
  - sum = sign-extended 17-bit al + ar;
  - saturated to [-32768, 32767];
  - mute applies after the mix.
- `AUDIO_PACER_MIX_EN` undefined: stereo pass-through, left = BGM and right = SFX; no adder is built.

## Test plan
- Player model that returns valid 1 cycle after ready, data 0x8000/0x8000, vol 0 → codec pair (0x0000, 0x0000). Exactly one request per CLK_DIV cycles.
- Data 0xFF00/0x0000, vol_bgm=1, vol_sfx=0, stereo → left 0x3F80, right 0x8000. With AUDIO_PACER_MIX_EN defined → both outputs 0xBF80.
- MIX_EN, 0xFF00+0xFF00, vol 0 → both outputs saturate to 0x7FFF. 0x0000+0x0000 → 0x8000.
- Valids held at 0 for 3 periods → 3 silence pushes, underrun_count=3, ready stays 1.
- codec_l_ready held 0 for 2 periods → overrun_count=1 and the latest sample is presented. Ready rising in the same cycle as a push → new sample is kept, no overrun.
- Reset asserted while in SETTLE_W → ready=0, all valids 0, counters 0 asynchronously. The first request occurs CLK_DIV cycles after release.
